// File: rtl/sample_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sample_iter_ctrl
// Description : Sample-test sequencer. Accepts one triangle with its screen
//               bounding box and walks the box on the MSAA sample grid in
//               row-major order, issuing one sample location per cycle with
//               the triangle and colour held alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_iter_ctrl #(
    parameter int SIGFIG = 24,  // bits in colour and position
    parameter int RADIX  = 10,  // fraction bits in position
    parameter int VERTS  = 3,   // vertices per triangle
    parameter int AXIS   = 3,   // axes per vertex
    parameter int COLORS = 3    // colour channels
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]            color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]              box_R13S,
    input  logic                                            validTri_R13H,
    input  logic        [3:0]                               subSample_RnnnnU,
    output logic                                            halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]            color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                   sample_R14S,
    output logic                                            validSamp_R14H
);

    typedef logic signed [SIGFIG-1:0] fix_t;
    typedef logic signed [SIGFIG:0]   ext_t;

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_TEST = 1'b1;

    // Grid pitch per MSAA mode, in fixed-point position units
    localparam fix_t STEP_1X  = fix_t'(1 << RADIX);
    localparam fix_t STEP_4X  = fix_t'(1 << (RADIX - 1));
    localparam fix_t STEP_16X = fix_t'(1 << (RADIX - 2));
    localparam fix_t STEP_64X = fix_t'(1 << (RADIX - 3));

    logic [0:0] state_q, state_d;
    logic       halt_q,  halt_d;
    logic       vld_q,   vld_d;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q,   tri_d;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;

    // Only ll.x and ur.x/ur.y are needed during the walk: y only ever grows
    fix_t llx_q,  llx_d;
    fix_t urx_q,  urx_d;
    fix_t ury_q,  ury_d;
    fix_t step_q, step_d;
    fix_t sx_q,   sx_d;
    fix_t sy_q,   sy_d;

    fix_t w_step_sel;
    fix_t w_ll_x, w_ll_y, w_ur_x, w_ur_y;
    logic w_box_ok;
    logic w_accept;
    ext_t w_nx, w_ny, w_urx_ext, w_ury_ext;
    logic w_x_fits, w_y_fits;

    // Decode the one-hot MSAA mode into a grid step; anything else is 1x
    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: w_step_sel = STEP_4X;
            4'b0010: w_step_sel = STEP_16X;
            4'b0001: w_step_sel = STEP_64X;
            default: w_step_sel = STEP_1X;
        endcase
    end

    assign w_ll_x   = $signed(box_R13S[0][0]);
    assign w_ll_y   = $signed(box_R13S[0][1]);
    assign w_ur_x   = $signed(box_R13S[1][0]);
    assign w_ur_y   = $signed(box_R13S[1][1]);
    assign w_box_ok = (w_ll_x <= w_ur_x) && (w_ll_y <= w_ur_y);
    assign w_accept = (state_q == ST_WAIT) && validTri_R13H;

    // One extra bit so the next grid position never wraps past ur
    assign w_nx      = {sx_q[SIGFIG-1], sx_q} + {1'b0, step_q};
    assign w_ny      = {sy_q[SIGFIG-1], sy_q} + {1'b0, step_q};
    assign w_urx_ext = {urx_q[SIGFIG-1], urx_q};
    assign w_ury_ext = {ury_q[SIGFIG-1], ury_q};
    assign w_x_fits  = (w_nx <= w_urx_ext);
    assign w_y_fits  = (w_ny <= w_ury_ext);

    // State register and all output/datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            halt_q  <= 1'b1;
            vld_q   <= 1'b0;
            tri_q   <= '0;
            color_q <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            vld_q   <= vld_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            step_q  <= step_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    // Next state: empty boxes are consumed without leaving WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (w_accept && w_box_ok) begin
                    state_d = ST_TEST;
                end
            end
            ST_TEST: begin
                if (!w_x_fits && !w_y_fits) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Next values of the registered outputs and walk datapath
    always_comb begin
        tri_d   = tri_q;
        color_d = color_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        step_d  = step_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        vld_d   = vld_q;
        halt_d  = (state_d == ST_WAIT);
        case (state_q)
            ST_WAIT: begin
                vld_d = 1'b0;
                if (w_accept && w_box_ok) begin
                    tri_d   = tri_R13S;
                    color_d = color_R13U;
                    llx_d   = w_ll_x;
                    urx_d   = w_ur_x;
                    ury_d   = w_ur_y;
                    step_d  = w_step_sel;
                    sx_d    = w_ll_x;
                    sy_d    = w_ll_y;
                    vld_d   = 1'b1;
                end
            end
            ST_TEST: begin
                if (w_x_fits) begin
                    sx_d = w_nx[SIGFIG-1:0];
                end else if (w_y_fits) begin
                    sx_d = llx_q;
                    sy_d = w_ny[SIGFIG-1:0];
                end else begin
                    vld_d = 1'b0;
                end
            end
            default: vld_d = 1'b0;
        endcase
    end

    assign halt_RnnnnL    = halt_q;
    assign validSamp_R14H = vld_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = sx_q;
    assign sample_R14S[1] = sy_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_iter_ctrl
// Description : Self-checking bench for sample_iter_ctrl with a queue-based
//               scoreboard fed by a box-walking reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_iter_ctrl;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic        [COLORS-1:0][SIGFIG-1:0]          col_t;
    typedef struct { int cyc; int x; int y; } exp_t;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    tri_t                            tri_in = '0;
    col_t                            col_in = '0;
    logic signed [1:0][1:0][SIGFIG-1:0] box_in = '0;
    logic                            vtri = 1'b0;
    logic [3:0]                      sub_in = 4'b1000;
    logic                            halt;
    tri_t                            tri_out;
    col_t                            col_out;
    logic signed [1:0][SIGFIG-1:0]   samp;
    logic                            vsamp;

    sample_iter_ctrl #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (col_in),
        .box_R13S         (box_in),
        .validTri_R13H    (vtri),
        .subSample_RnnnnU (sub_in),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (col_out),
        .sample_R14S      (samp),
        .validSamp_R14H   (vsamp)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    int   busy_end = 0;   // first cycle in which the model expects halt high
    tri_t last_tri = '0;
    col_t last_col = '0;
    bit   mon_en   = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int step_of(input logic [3:0] s);
        case (s)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Scoreboard monitor: compares every cycle against the model state
    always @(negedge clk) begin
        bit   exp_v;
        exp_t e;
        if (mon_en) begin
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            check("valid", 256'(vsamp), 256'(exp_v));
            check("halt", 256'(halt), 256'(cyc >= busy_end));
            check("tri", 256'(tri_out), 256'(last_tri));
            check("color", 256'(col_out), 256'(last_col));
            if (exp_v) begin
                e = q.pop_front();
                if (vsamp) begin
                    check("samp_x", 256'(longint'($signed(samp[0]))), 256'(longint'(e.x)));
                    check("samp_y", 256'(longint'($signed(samp[1]))), 256'(longint'(e.y)));
                end
            end
        end
    end

    // Present a triangle, wait until the model says it is accepted, then
    // enqueue the row-major walk of its box.
    task automatic drive(input tri_t t, input col_t c, input int llx, input int lly,
                         input int urx, input int ury, input logic [3:0] s,
                         input bit hold, output int acc);
        int n;
        int st;
        int k;
        @(negedge clk);
        tri_in = t;
        col_in = c;
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        sub_in = s;
        vtri   = 1'b1;
        n = 0;
        while (cyc < busy_end) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                failures++;
                $display("FAIL accept_timeout cyc=%0d actual=busy required=ready", cyc);
                $fatal(1, "accept wait expired");
            end
        end
        acc = cyc + 1;
        @(posedge clk);
        st = step_of(s);
        if (llx <= urx && lly <= ury) begin
            k = 0;
            for (int y = lly; y <= ury; y += st)
                for (int x = llx; x <= urx; x += st) begin
                    q.push_back('{acc + k, x, y});
                    k++;
                end
            busy_end = acc + k;
            last_tri = t;
            last_col = c;
        end
        if (!hold) begin
            @(negedge clk);
            vtri = 1'b0;
        end
    endtask

    function automatic tri_t rnd_tri();
        tri_t t;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[v][a] = SIGFIG'($urandom);
        return t;
    endfunction

    function automatic col_t rnd_col();
        col_t c;
        for (int i = 0; i < COLORS; i++) c[i] = SIGFIG'($urandom);
        return c;
    endfunction

    task automatic check_zero(input string nm);
        check({nm, "_valid"}, 256'(vsamp), 256'(0));
        check({nm, "_halt"}, 256'(halt), 256'(1));
        check({nm, "_tri"}, 256'(tri_out), 256'(0));
        check({nm, "_color"}, 256'(col_out), 256'(0));
        check({nm, "_samp"}, 256'(samp), 256'(0));
    endtask

    initial begin
        int p;
        int n;
        logic [3:0] subs [7];
        subs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0110, 4'b1111};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // 1x walk of a 3x2 box
        drive(rnd_tri(), rnd_col(), 0, 0, 2048, 1024, 4'b1000, 1'b0, p);
        // 4x with unaligned ur: 2x2, never x=1024
        drive(rnd_tri(), rnd_col(), 0, 0, 700, 600, 4'b0100, 1'b0, p);
        // single-point box
        drive(rnd_tri(), rnd_col(), -1024, -1024, -1024, -1024, 4'b1000, 1'b0, p);
        // empty box then a normal one right after
        drive(rnd_tri(), rnd_col(), 1024, 0, 0, 0, 4'b1000, 1'b0, p);
        drive(rnd_tri(), rnd_col(), 0, 0, 1024, 0, 4'b0010, 1'b0, p);
        // back-to-back with valid held high
        drive(rnd_tri(), rnd_col(), 0, 0, 1024, 1024, 4'b1000, 1'b1, p);
        drive(rnd_tri(), rnd_col(), 512, 512, 1024, 512, 4'b0100, 1'b0, p);

        // reset on the 3rd sample of a 3x2 walk
        drive(rnd_tri(), rnd_col(), 0, 0, 2048, 1024, 4'b1000, 1'b0, p);
        @(negedge clk);
        @(negedge clk);
        #1;
        q.delete();
        busy_end = cyc + 1;
        last_tri = '0;
        last_col = '0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_zero("midreset");
        rst = 1'b0;

        // randomized triangles, including non-one-hot modes and empty boxes
        for (int i = 0; i < 40; i++) begin
            logic [3:0] s;
            int st, llx, lly, urx, ury;
            s   = subs[$urandom_range(0, 6)];
            st  = step_of(s);
            llx = (int'($urandom_range(0, 200)) - 100) * st;
            lly = (int'($urandom_range(0, 200)) - 100) * st;
            urx = llx + int'($urandom_range(0, 3)) * st + int'($urandom_range(0, st - 1));
            ury = lly + int'($urandom_range(0, 3)) * st + int'($urandom_range(0, st - 1));
            if ($urandom_range(0, 9) == 0) urx = llx - int'($urandom_range(1, st));
            if ($urandom_range(0, 9) == 0) ury = lly - int'($urandom_range(1, st));
            drive(rnd_tri(), rnd_col(), llx, lly, urx, ury, s, 1'($urandom_range(0, 1)), p);
        end
        @(negedge clk);
        vtri = 1'b0;

        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending samples", q.size());
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
